// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the UART serialiser: FSM states, parity modes,
// frame-length clamping and stop-bit duration.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Parity mode is {sticky_parity, eps}
  localparam logic [1:0] PAR_ODD   = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  localparam int unsigned MIN_LEN = 5;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    int unsigned r;
    r = len;
    if (len < MIN_LEN) r = MIN_LEN;
    else if (len > max_len) r = max_len;
    return r;
  endfunction

  // 1.5 stop bits only apply to 5-bit frames; other lengths get 2 with stb set.
  function automatic int unsigned stop_ticks(input logic stb, input int unsigned len,
                                             input int unsigned ovs);
    int unsigned r;
    r = ovs;
    if (stb) r = (len == MIN_LEN) ? (3 * ovs) / 2 : 2 * ovs;
    return r;
  endfunction

  function automatic logic parity_bit(input logic [1:0] mode, input logic x);
    logic r;
    case (mode)
      PAR_ODD:  r = ~x;
      PAR_EVEN: r = x;
      PAR_MARK: r = 1'b1;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Down-counter paced by baud_pulse; done marks the final tick of a loaded
// interval. Shared between the TX and RX paths.
module uart_bit_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A load on the same edge as a tick wins, so back-to-back intervals chain
  always_comb begin
    cnt_d = cnt_q;
    if (load) cnt_d = load_val;
    else if (tick && (cnt_q != '0)) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = tick && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame serialiser: start, 5..DATA_W data bits LSB first, optional parity,
// 1/1.5/2 stop bits. Define UART_AUTO_CTS_EN to gate frame loads on cts_n.
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int OVS    = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud_pulse,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic [LEN_W-1:0]  len,
  input  logic              pen,
  input  logic              eps,
  input  logic              sticky_parity,
  input  logic              stb,
  input  logic              set_break,
`ifdef UART_AUTO_CTS_EN
  input  logic              cts_n,
`endif
  output logic              pop,
  output logic              sreg_empty,
  output logic              busy,
  output logic              tx
);

  localparam int CNT_W = $clog2(2 * OVS);
  localparam logic [CNT_W-1:0] BIT_TICKS = CNT_W'(OVS - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  bitcnt_q, bitcnt_d;
  logic              stb_q, stb_d;
  logic              pen_q, pen_d;
  logic              par_q, par_d;
  logic              line_q, line_d;
  logic              busy_q, busy_d;
  logic              empty_q, empty_d;
  logic              pop_q, pop_d;
  logic              tx_q;

  logic              can_load;
  logic              do_load;
  logic              bit_done;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic [CNT_W-1:0]  stop_val;
  logic [LEN_W-1:0]  len_clamped;
  logic [DATA_W-1:0] data_mask;
  logic              load_parity;

`ifdef UART_AUTO_CTS_EN
  assign can_load = din_valid & ~cts_n;
`else
  assign can_load = din_valid;
`endif

  assign len_clamped = LEN_W'(clamp_len(32'(len), 32'(DATA_W)));

  // Parity covers only the bits actually sent, so mask by the clamped length
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
    assign data_mask[gi] = (LEN_W'(gi) < len_clamped);
  end

  assign load_parity = parity_bit({sticky_parity, eps}, ^(din & data_mask));
  assign stop_val    = CNT_W'(stop_ticks(stb_q, 32'(len_q), 32'(OVS)) - 32'd1);

  uart_bit_timer #(
    .CNT_W (CNT_W)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (baud_pulse),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (bit_done)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    len_d    = len_q;
    bitcnt_d = bitcnt_q;
    stb_d    = stb_q;
    pen_d    = pen_q;
    par_d    = par_q;
    line_d   = line_q;
    busy_d   = busy_q;
    empty_d  = empty_q;
    pop_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    do_load  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (baud_pulse && can_load) do_load = 1'b1;
      end
      ST_START: begin
        if (bit_done) begin
          state_d  = ST_DATA;
          line_d   = shreg_q[0];
          shreg_d  = shreg_q >> 1;
          bitcnt_d = LEN_W'(1);
          tmr_load = 1'b1;
          tmr_val  = BIT_TICKS;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          tmr_load = 1'b1;
          if (bitcnt_q == len_q) begin
            if (pen_q) begin
              state_d = ST_PARITY;
              line_d  = par_q;
              tmr_val = BIT_TICKS;
            end else begin
              state_d = ST_STOP;
              line_d  = 1'b1;
              empty_d = 1'b1;
              tmr_val = stop_val;
            end
          end else begin
            line_d   = shreg_q[0];
            shreg_d  = shreg_q >> 1;
            bitcnt_d = bitcnt_q + LEN_W'(1);
            tmr_val  = BIT_TICKS;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d  = ST_STOP;
          line_d   = 1'b1;
          empty_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = stop_val;
        end
      end
      ST_STOP: begin
        // The final stop tick doubles as the load tick: no idle gap between frames
        if (bit_done) begin
          if (can_load) begin
            do_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_load) begin
      state_d  = ST_START;
      shreg_d  = din;
      len_d    = len_clamped;
      stb_d    = stb;
      pen_d    = pen;
      par_d    = load_parity;
      bitcnt_d = '0;
      line_d   = 1'b0;
      busy_d   = 1'b1;
      empty_d  = 1'b0;
      pop_d    = 1'b1;
      tmr_load = 1'b1;
      tmr_val  = BIT_TICKS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      len_q    <= '0;
      bitcnt_q <= '0;
      stb_q    <= 1'b0;
      pen_q    <= 1'b0;
      par_q    <= 1'b0;
      line_q   <= 1'b1;
      busy_q   <= 1'b0;
      empty_q  <= 1'b1;
      pop_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      len_q    <= len_d;
      bitcnt_q <= bitcnt_d;
      stb_q    <= stb_d;
      pen_q    <= pen_d;
      par_q    <= par_d;
      line_q   <= line_d;
      busy_q   <= busy_d;
      empty_q  <= empty_d;
      pop_q    <= pop_d;
      // Break masks the line without stalling the frame underneath
      tx_q     <= line_q & ~set_break;
    end
  end

  assign pop        = pop_q;
  assign sreg_empty = empty_q;
  assign busy       = busy_q;
  assign tx         = tx_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: a FIFO model feeds words, a reference
// model predicts each frame's per-tick line level, a monitor checks it.
module tb_uart_tx_frame;

  localparam int OVS    = 16;
  localparam int DATA_W = 8;
  localparam int LEN_W  = $clog2(DATA_W + 1);
  localparam int MAXW   = 64;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [LEN_W-1:0]  l;
    logic              pen;
    logic              eps;
    logic              stk;
    logic              stb;
  } word_t;

  typedef struct {
    logic [15:0] bits;   // start, data, optional parity (index = bit slot)
    int          nbits;
    int          nstop;
    bit          b2b;    // expected to load straight off the previous stop bit
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic baud_pulse = 1'b0;
  logic set_break = 1'b0;
  logic brk_d = 1'b0;
  logic [DATA_W-1:0] din;
  logic din_valid;
  logic [LEN_W-1:0] len;
  logic pen, eps, sticky_parity, stb;
  logic pop, sreg_empty, busy, tx;
`ifdef UART_AUTO_CTS_EN
  logic cts_n = 1'b0;
`endif

  word_t  wq [MAXW];
  int     wr_idx = 0;
  int     rd_idx = 0;
  frame_t sb [$];

  int checks = 0;
  int errors = 0;
  bit stim_done = 1'b0;
  bit mon_done = 1'b0;
  bit brk_off = 1'b0;

  always #5 clk = ~clk;

  uart_tx_frame #(
    .OVS    (OVS),
    .DATA_W (DATA_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .baud_pulse    (baud_pulse),
    .din           (din),
    .din_valid     (din_valid),
    .len           (len),
    .pen           (pen),
    .eps           (eps),
    .sticky_parity (sticky_parity),
    .stb           (stb),
    .set_break     (set_break),
`ifdef UART_AUTO_CTS_EN
    .cts_n         (cts_n),
`endif
    .pop           (pop),
    .sreg_empty    (sreg_empty),
    .busy          (busy),
    .tx            (tx)
  );

  // FIFO model: the head word and its frame configuration drive the DUT inputs
  always @* begin
    din_valid     = (rd_idx < wr_idx);
    din           = wq[rd_idx % MAXW].d;
    len           = wq[rd_idx % MAXW].l;
    pen           = wq[rd_idx % MAXW].pen;
    eps           = wq[rd_idx % MAXW].eps;
    sticky_parity = wq[rd_idx % MAXW].stk;
    stb           = wq[rd_idx % MAXW].stb;
  end

  always @(posedge clk) begin
    if (pop === 1'b1) rd_idx <= rd_idx + 1;
    brk_d <= set_break;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  // Reference model: the frame as a list of bit slots plus a stop duration
  function automatic frame_t model(input word_t w, input bit b2b);
    frame_t f;
    int L, ones;
    bit pb;
    L = int'(w.l);
    if (L < 5) L = 5;
    if (L > DATA_W) L = DATA_W;
    f.bits = '0;
    ones = 0;
    for (int i = 0; i < L; i++) begin
      f.bits[1+i] = w.d[i];
      if (w.d[i]) ones++;
    end
    f.nbits = 1 + L;
    if (w.pen) begin
      if (w.stk)      pb = !w.eps;
      else if (w.eps) pb = ((ones % 2) == 1);
      else            pb = ((ones % 2) == 0);
      f.bits[f.nbits] = pb;
      f.nbits++;
    end
    if (!w.stb)      f.nstop = OVS;
    else if (L == 5) f.nstop = OVS + OVS / 2;
    else             f.nstop = 2 * OVS;
    f.b2b = b2b;
    return f;
  endfunction

  task automatic push_word(input word_t w, input bit b2b);
    wq[wr_idx % MAXW] = w;
    sb.push_back(model(w, b2b));
    wr_idx++;
  endtask

  task automatic push_raw(input word_t w);
    wq[wr_idx % MAXW] = w;
    wr_idx++;
  endtask

  function automatic word_t mk(input logic [7:0] d, input int l, input bit p, input bit e,
                               input bit s, input bit st);
    word_t w;
    w.d = d; w.l = LEN_W'(l); w.pen = p; w.eps = e; w.stk = s; w.stb = st;
    return w;
  endfunction

  function automatic word_t rnd_word();
    word_t w;
    w.d   = DATA_W'($urandom);
    w.l   = LEN_W'($urandom_range(0, 15));
    w.pen = 1'($urandom_range(0, 1));
    w.eps = 1'($urandom_range(0, 1));
    w.stk = 1'($urandom_range(0, 1));
    w.stb = 1'($urandom_range(0, 1));
    return w;
  endfunction

  task automatic wait_idle();
    int t;
    t = 0;
    while (!((rd_idx == wr_idx) && (busy === 1'b0)) && t < 40000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 40000) begin
      $display("FAIL idle_timeout got=busy required=idle");
      $fatal(1, "transmitter never went idle");
    end
    repeat ($urandom_range(0, 8)) @(posedge clk);
    #1;
  endtask

  // Baud strobe: one clk high, gaps of 2..4 clks between strobes
  initial begin : baud_gen
    forever begin
      @(posedge clk); #1 baud_pulse = 1'b1;
      @(posedge clk); #1 baud_pulse = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  end

  initial begin : break_gen
    @(posedge rst_n);
    while (!stim_done) begin
      repeat ($urandom_range(150, 700)) @(posedge clk);
      #1 set_break = 1'b1;
      repeat ($urandom_range(3, 40)) @(posedge clk);
      #1 set_break = 1'b0;
    end
    brk_off = 1'b1;
  end

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1, "simulation time limit");
  end

  // Monitor: one frame per observed pop, sampled on every baud strobe
  initial begin : monitor
    frame_t f;
    bit pending, first, nb, lvl, stp;
    int fidx, k, mism, total, slot, t;
    logic [2:0] got3, exp3;
    pending = 1'b0;
    fidx = 0;
    @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_sreg_empty", sreg_empty, 1);
    check("reset_pop", pop, 0);
    while (1) begin
      if (!pending) begin
        t = 0;
        while (pop !== 1'b1 && !(stim_done && sb.size() == 0) && t < 20000) begin
          @(negedge clk);
          t++;
        end
        if (pop !== 1'b1) begin
          if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL pop_timeout got=no_pop required=pop");
          end
          break;
        end
      end
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pop got=pop required=no_pop");
        break;
      end
      f = sb.pop_front();
      total = f.nbits * OVS + f.nstop;
      k = 0; mism = 0; first = 1'b1;
      while (k < total) begin
        @(negedge clk);
        if (first) check("pop_width", pop, 0);
        first = 1'b0;
        if (baud_pulse === 1'b1) begin
          slot = k / OVS;
          if (slot < f.nbits) begin lvl = f.bits[slot]; stp = 1'b0; end
          else begin lvl = 1'b1; stp = 1'b1; end
          exp3 = {lvl & ~brk_d, stp, 1'b1};
          got3 = {tx, sreg_empty, busy};
          if (got3 !== exp3) begin
            if (mism == 0)
              $display("  frame %0d tick %0d tx/empty/busy=%b expected %b", fidx, k, got3, exp3);
            mism++;
          end
          k++;
        end
      end
      check("frame_ticks_wrong", mism, 0);
      @(negedge clk);
      nb = (sb.size() > 0) && sb[0].b2b;
      check("frame_end_pop_busy_empty", {29'd0, pop, busy, sreg_empty}, nb ? 32'h6 : 32'h1);
      pending = (pop === 1'b1);
      fidx++;
    end
    mon_done = 1'b1;
  end

  initial begin : stimulus
    int t, pc;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    push_word(mk(8'hA5, 8, 0, 0, 0, 0), 1'b0); wait_idle();
    push_word(mk(8'h55, 7, 1, 1, 0, 0), 1'b0); wait_idle();
    push_word(mk(8'h55, 7, 1, 0, 0, 0), 1'b0); wait_idle();
    push_word(mk(8'h55, 7, 1, 0, 1, 0), 1'b0); wait_idle();
    push_word(mk(8'h55, 7, 1, 1, 1, 0), 1'b0); wait_idle();
    push_word(mk(8'h1B, 5, 0, 0, 0, 1), 1'b0); wait_idle();
    push_word(mk(8'hC3, 8, 0, 0, 0, 1), 1'b0); wait_idle();
    push_word(mk(8'h0F, 2, 1, 1, 0, 0), 1'b0); wait_idle();
    push_word(mk(8'hF0, 12, 1, 0, 0, 1), 1'b0); wait_idle();
    for (int i = 0; i < 3; i++) push_word(mk(8'($urandom), 8, 0, 0, 0, 0), i > 0);
    wait_idle();
    for (int b = 0; b < 6; b++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) push_word(rnd_word(), i > 0);
      if (b == 5) stim_done = 1'b1;
      else wait_idle();
    end

    t = 0;
    while (!(mon_done && brk_off) && t < 60000) begin @(posedge clk); t++; end
    if (t >= 60000) begin
      $display("FAIL monitor_timeout got=running required=done");
      $fatal(1, "monitor did not finish");
    end
    wait_idle();

    // Asynchronous reset in the middle of the data bits
    push_raw(mk(8'h3C, 8, 0, 0, 0, 0));
    push_raw(mk(8'h81, 8, 0, 0, 0, 0));
    t = 0;
    while (pop !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    check("reset_phase_first_pop", pop, 1);
    pc = 0;
    while (pc < 3 * OVS) begin @(negedge clk); if (baud_pulse === 1'b1) pc++; end
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("async_reset_tx", tx, 1);
    check("async_reset_busy", busy, 0);
    check("async_reset_sreg_empty", sreg_empty, 1);
    check("async_reset_pop", pop, 0);
`ifdef UART_AUTO_CTS_EN
    cts_n = 1'b1;
`endif
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
`ifdef UART_AUTO_CTS_EN
    pc = 0; t = 0;
    while (pc < 40) begin
      @(negedge clk);
      if (baud_pulse === 1'b1) pc++;
      if (pop === 1'b1) t++;
    end
    check("cts_blocks_pop", t, 0);
    @(posedge clk); #1 cts_n = 1'b0;
`endif
    pc = 0; t = 0;
    while (pop !== 1'b1 && t < 200) begin
      @(negedge clk);
      if (baud_pulse === 1'b1) pc++;
      t++;
    end
    check("pulses_to_pop_after_reset", pc, 1);
    t = 0;
    while (t < 20) begin
      @(negedge clk);
      if (baud_pulse === 1'b1) break;
      t++;
    end
    check("start_bit_after_reset", {30'd0, tx, busy}, 32'h1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART serialiser for the 16550-style core. It takes words from the TX FIFO and drives the serial line with this frame: start bit, 5..DATA_W data bits sent LSB first, optional parity, then 1, 1.5 or 2 stop bits. Bit timing comes from the oversampling baud_pulse strobe.
Compared with the previous transmitter it adds:
- a correct low start bit;
- a generic oversample ratio and word width;
- frame configuration latched at load time;
- back-to-back frames with no idle gap;
- a busy output.

Parameters:
- OVS, 16: baud_pulse ticks per bit. Must be even and at least 4.
- DATA_W, 8: maximum data bits per frame. Legal range 5..9.
- LEN_W, $clog2(DATA_W+1): width of the len port.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- baud_pulse  in  1  one-clk strobe, OVS strobes per bit
- din  in  DATA_W  FIFO head word
- din_valid  in  1  FIFO non-empty (inverse of csr.lsr.thres)
- len  in  LEN_W  data bits per frame
- pen  in  1  parity enable
- eps  in  1  even parity select
- sticky_parity  in  1  sticky (stick) parity
- stb  in  1  stop bit select
- set_break  in  1  force line low
- pop  out  1  one-clk FIFO read strobe
- sreg_empty  out  1  shift register empty (feeds TEMT)
- busy  out  1  frame in progress
- tx  out  1  serial line, registered

Behaviour:
- Reset values (asynchronous, effective immediately, including mid-frame):
  - tx=1, pop=0, sreg_empty=1, busy=0.
  - State is IDLE and every counter is 0.
- All state, counter and shift activity advances only on clk edges where baud_pulse=1. The exceptions are pop and tx, described below.
- States: IDLE, START, DATA, PARITY, STOP.
- Load event: on a baud_pulse while in IDLE, or on the last tick of STOP, with din_valid=1. On a load:
  - Latch din, len, pen, eps, sticky_parity and stb.
  - Assert pop for exactly that one clk.
  - Set busy=1 and sreg_empty=0.
  - Go to START with the bit counter at OVS-1 and the line bit at 0.
- Configuration changes while a frame is in progress have no effect until the next load.
- len clamping: a value below 5 is treated as 5; a value above DATA_W is treated as DATA_W.
- Bit period: START, DATA and PARITY each hold for exactly OVS baud_pulses per bit.
- DATA: shift out LSB first. After len bits, go to PARITY if pen=1, otherwise go to STOP.
- Parity value, computed as x = XOR of the latched len data bits:
  - sticky=0, eps=0 (odd): parity bit = ~x.
  - sticky=0, eps=1 (even): parity bit = x.
  - sticky=1, eps=0: parity bit = 1.
  - sticky=1, eps=1: parity bit = 0.
- STOP: line bit is 1. Duration:
  - stb=0: OVS ticks.
  - stb=1 and len=5: 3*OVS/2 ticks.
  - stb=1 and len>5: 2*OVS ticks.
- sreg_empty goes to 1 on entry to STOP.
- At the end of STOP:
  - If din_valid=1: load immediately, with zero idle ticks between frames.
  - Otherwise: go to IDLE and set busy=0.
- Line output: tx is registered, tx = line_bit & ~set_break, one clk after the line bit changes.
  - set_break does not pause the FSM. The frame keeps advancing underneath while the line is held low.
- din_valid dropping mid-frame has no effect on the current frame.
- A baud_pulse that coincides with a load is consumed by the load. The START bit then receives OVS full ticks after it.

Optional Feature:
- Macro: UART_AUTO_CTS_EN.
- When defined:
  - Adds input cts_n (1 bit, already synchronised).
  - A load happens only if cts_n=0 as well as the existing load conditions.
  - A frame already in progress always completes.
  - When cts_n=1 at the end of STOP, the block goes to IDLE.
- When undefined: the port is absent and loads depend only on din_valid.

Decomposition:
- Package uart_tx_pkg contains:
  - the state enum typedef tx_state_t;
  - parity-mode localparams;
  - the function stop_ticks(stb, len, OVS);
  - the function clamp_len.
- Sub-module uart_bit_timer is natural. It is a down-counter loaded with a tick count and advanced by baud_pulse, with a done output on the last tick. It is shared with the future RX block.

Test Plan:
- OVS=16, 8N1, din=0xA5, one word. Required response:
  - pop is high for exactly 1 clk.
  - tx sequence is 0, 1,0,1,0,0,1,0,1, then 1, with each bit lasting 16 pulses.
  - busy falls 16 pulses after the stop bit begins.
- len=7, pen=1, din=0x55:
  - eps=1: parity bit = 0.
  - eps=0: parity bit = 1.
  - sticky=1, eps=0: parity bit = 1.
  - sticky=1, eps=1: parity bit = 0.
- len=5, stb=1: stop bit lasts 24 pulses. len=8, stb=1: stop bit lasts 32 pulses.
- 3 words queued with din_valid held high:
  - 3 pop pulses, spaced exactly 160 pulses apart for 8N1.
  - tx never idles between frames.
  - sreg_empty toggles once per frame.
- set_break asserted mid-frame:
  - tx is 0 from the next clk.
  - On release, tx resumes at the current FSM bit position.
  - Frame length is unchanged.
- rst_n low in the middle of DATA:
  - tx=1, busy=0, sreg_empty=1 asynchronously.
  - After release and with din_valid=1, the next baud_pulse produces a new pop and START.
  - With UART_AUTO_CTS_EN defined and cts_n=1, no pop occurs until cts_n=0.
